// File: rtl/tt_um_vga_example.sv
// 640x480 VGA timing generator with an animated 8-fold-symmetric "mandala" pattern.
// One pixel per clk; all outputs registered so sync and colour stay aligned.
//
// Ports:
//   clk      pixel clock
//   rst_n    synchronous active-low reset
//   ena      design enable (ignored)
//   ui_in    [0]=pause animation, [2:1]=pattern mode, [7:3] unused
//   uio_in   unused
//   uo_out   TinyVGA PMOD: {HSYNC, B0, G0, R0, VSYNC, B1, G1, R1}
//   uio_out  tied 0
//   uio_oe   tied 0 (all bidirectionals are inputs)
module tt_um_vga_example (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [9:0] HActive    = 10'd640;
  localparam logic [9:0] HSyncStart = 10'd656;
  localparam logic [9:0] HSyncEnd   = 10'd751;
  localparam logic [9:0] HLast      = 10'd799;
  localparam logic [9:0] VActive    = 10'd480;
  localparam logic [9:0] VSyncStart = 10'd490;
  localparam logic [9:0] VSyncEnd   = 10'd491;
  localparam logic [9:0] VLast      = 10'd524;

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] uo_d;

  logic [9:0] dx, dy, a, b, ring;
  logic [5:0] idx, p, c, rgb;
  logic       hsync_n, vsync_n, active;

  // Counter next-state
  always_comb begin
    hpos_d  = hpos_q + 10'd1;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (hpos_q == HLast) begin
      hpos_d = 10'd0;
      vpos_d = (vpos_q == VLast) ? 10'd0 : vpos_q + 10'd1;
      // Pause freezes only the animation; raster timing keeps running.
      if ((vpos_q == VLast) && !ui_in[0]) begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  // Pattern: distance-like ring index from screen centre plus XOR texture,
  // both symmetric under x/y mirroring and x<->y swap.
  always_comb begin
    dx   = (hpos_q >= 10'd320) ? hpos_q - 10'd320 : 10'd319 - hpos_q;
    dy   = (vpos_q >= 10'd240) ? vpos_q - 10'd240 : 10'd239 - vpos_q;
    a    = (dx >= dy) ? dx : dy;
    b    = (dx >= dy) ? dy : dx;
    ring = a + {1'b0, b[9:1]};
    idx  = ring[7:2] + frame_q[5:0];
    p    = a[5:0] ^ b[5:0];
    c    = 6'd0;
    unique case (ui_in[2:1])
      2'b00: c = idx ^ p;
      2'b01: c = idx;
      2'b10: c = p;
      2'b11: c = ~(idx ^ p);
      default: c = 6'd0;
    endcase
  end

  always_comb begin
    hsync_n = !((hpos_q >= HSyncStart) && (hpos_q <= HSyncEnd));
    vsync_n = !((vpos_q >= VSyncStart) && (vpos_q <= VSyncEnd));
    active  = (hpos_q < HActive) && (vpos_q < VActive);
    rgb     = active ? c : 6'd0;
    // rgb = {R1, R0, G1, G0, B1, B0}
    uo_d    = {hsync_n, rgb[0], rgb[2], rgb[4], vsync_n, rgb[1], rgb[3], rgb[5]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      frame_q <= 8'd0;
      uo_out  <= 8'h88;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
      uo_out  <= uo_d;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_vga_example.sv
`timescale 1ns/1ps
module tb_tt_um_vga_example;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_vga_example dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // sel: 0 = uo_out, 1 = uio_out, 2 = uio_oe
  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [7:0]  val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  int unsigned gcyc = 0;  // rising edges since time 0
  int unsigned ncyc = 0;  // rising edges since last reset release
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d)", name, actual, actual,
               expected, expected);
    end
  endtask

  // Monitor: scoreboard compare plus continuous raster observation
  bit          track = 0;
  logic        hs_prev = 1'b1, vs_prev = 1'b1;
  int unsigned hs_fall_q[$], hs_rise_q[$], vs_fall_q[$], vs_rise_q[$];
  int          hs_tr = 0, vs_tr = 0;
  int          blank_viol = 0, sync_viol = 0, uio_viol = 0;

  always @(negedge clk) begin
    int          act;
    int unsigned pos, h, v;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == gcyc) begin
        case (exp_q[i].sel)
          1:       act = int'(uio_out);
          2:       act = int'(uio_oe);
          default: act = int'(uo_out);
        endcase
        check(exp_q[i].name, act, int'(exp_q[i].val));
        exp_q.delete(i);
      end else if (exp_q[i].cyc < gcyc) begin
        check({exp_q[i].name, "_missed"}, int'(gcyc), int'(exp_q[i].cyc));
        exp_q.delete(i);
      end
    end
    if (track) begin
      if (uo_out[7] !== hs_prev) begin
        hs_tr++;
        if (!uo_out[7]) hs_fall_q.push_back(gcyc);
        else            hs_rise_q.push_back(gcyc);
      end
      if (uo_out[3] !== vs_prev) begin
        vs_tr++;
        if (!uo_out[3]) vs_fall_q.push_back(gcyc);
        else            vs_rise_q.push_back(gcyc);
      end
      hs_prev = uo_out[7];
      vs_prev = uo_out[3];
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) uio_viol++;
      if (rst_n && ncyc >= 1) begin
        pos = ncyc - 1;
        h   = pos % 800;
        v   = (pos / 800) % 525;
        if ((h >= 640 || v >= 480) && ((uo_out & 8'h77) !== 8'h00)) blank_viol++;
        if (uo_out[7] !== !(h >= 656 && h <= 751)) sync_viol++;
        if (uo_out[3] !== !(v >= 490 && v <= 491)) sync_viol++;
      end
    end
  end

  int unsigned rel, rel1;

  task automatic push_exp(input int unsigned t, input int sel, input logic [7:0] val,
                          input string name);
    exp_t e;
    e.cyc  = t;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive ui for pixel (h,v) of frame f (relative to release) and expect val on uo_out.
  task automatic expect_px(input int unsigned f, input int unsigned v, input int unsigned h,
                           input logic [7:0] ui, input logic [7:0] val, input string name);
    int unsigned t = rel + f * 420000 + v * 800 + h + 1;
    while (gcyc + 1 < t) @(negedge clk);
    ui_in = ui;
    push_exp(t, 0, val, name);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h02;
    uio_in = 8'h00;
    repeat (4) @(negedge clk);
    push_exp(gcyc + 1, 0, 8'h88, "reset_uo_out");
    push_exp(gcyc + 1, 1, 8'h00, "reset_uio_out");
    push_exp(gcyc + 1, 2, 8'h00, "reset_uio_oe");
    @(negedge clk);
    rst_n = 1'b1;
    rel   = gcyc;
    rel1  = gcyc;
    track = 1;

    // Frame 0
    expect_px(0,   0,   0, 8'h02, 8'hEB, "px0_0_mode01");
    expect_px(0,   0,   1, 8'h00, 8'hBB, "px1_0_mode00");
    expect_px(0,   0,   2, 8'h04, 8'h9C, "px2_0_mode10");
    expect_px(0,   0,   3, 8'h06, 8'h88, "px3_0_mode11");
    expect_px(0,   0, 639, 8'h02, 8'hEB, "last_active_col");
    expect_px(0,   0, 640, 8'h02, 8'h88, "first_blank_col");
    expect_px(0,   0, 655, 8'h02, 8'h88, "pre_hsync");
    expect_px(0,   0, 656, 8'h02, 8'h08, "hsync_first");
    expect_px(0,   0, 751, 8'h02, 8'h08, "hsync_last");
    expect_px(0,   0, 752, 8'h02, 8'h88, "post_hsync");
    expect_px(0, 200, 100, 8'h00, 8'hEC, "px100_200_mode00");
    expect_px(0, 240, 320, 8'h00, 8'h88, "centre_mode00");
    expect_px(0, 300, 400, 8'h02, 8'hDE, "px400_300_mode01");
    expect_px(0, 479, 639, 8'h02, 8'hEB, "last_active_px");
    expect_px(0, 480,   0, 8'h02, 8'h88, "first_blank_line");
    expect_px(0, 490,   5, 8'h02, 8'h80, "vsync_first");
    expect_px(0, 491,   5, 8'h02, 8'h80, "vsync_last");
    expect_px(0, 492,   5, 8'h02, 8'h88, "post_vsync");

    // Frame 1: animation advanced by one
    expect_px(1,   0,   0, 8'h02, 8'hAF, "f1_px0_0");
    expect_px(1, 300, 400, 8'h02, 8'hBA, "f1_px400_300");
    expect_px(1, 400,   0, 8'h03, 8'hA9, "f1_px0_400_paused");

    // Frame 2 with pause held across the boundary: frame stays at 1
    expect_px(2,   0,   0, 8'h03, 8'hAF, "f2_px0_0_paused");
    expect_px(2,   3, 100, 8'h03, 8'hFC, "f2_px100_3_paused");

    // Mid-line reset, then restart from hpos=0 with frame cleared
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = 8'h02;
    push_exp(gcyc + 3, 0, 8'h88, "mid_reset_uo_out");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel   = gcyc;
    expect_px(0,   0,   0, 8'h02, 8'hEB, "post_reset_px0_0");
    expect_px(0,   0,   1, 8'h02, 8'hEB, "post_reset_px1_0");
    expect_px(0,   0, 655, 8'h02, 8'h88, "post_reset_pre_hsync");
    expect_px(0,   0, 656, 8'h02, 8'h08, "post_reset_hsync");
    repeat (4) @(negedge clk);

    // Raster timing from the first uninterrupted run
    check("hsync_first_fall", int'(hs_fall_q.size() >= 1 ? hs_fall_q[0] - rel1 : 0), 657);
    check("hsync_period", int'(hs_fall_q.size() >= 2 ? hs_fall_q[1] - hs_fall_q[0] : 0), 800);
    check("hsync_width", int'(hs_rise_q.size() >= 1 && hs_fall_q.size() >= 1 ?
                              hs_rise_q[0] - hs_fall_q[0] : 0), 96);
    check("vsync_first_fall", int'(vs_fall_q.size() >= 1 ? vs_fall_q[0] - rel1 : 0), 392001);
    check("vsync_period", int'(vs_fall_q.size() >= 2 ? vs_fall_q[1] - vs_fall_q[0] : 0),
          420000);
    check("vsync_width", int'(vs_rise_q.size() >= 1 && vs_fall_q.size() >= 1 ?
                              vs_rise_q[0] - vs_fall_q[0] : 0), 1600);
    check("hsync_transitions_ge_1050", int'(hs_tr >= 1050), 1);
    check("vsync_transitions_ge_4", int'(vs_tr >= 4), 1);
    check("blanking_violations", blank_viol, 0);
    check("sync_violations", sync_viol, 0);
    check("uio_violations", uio_viol, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #12_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", gcyc);
    $fatal(1, "watchdog expired");
  end

endmodule
